ecc_scrub_ctrl: RTL and testbench

ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

---
 rtl/ecc_scrub_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// SECDED-protected memory controller: a host read/write port plus a background scrubber
// that rewrites single-bit errors in place and logs uncorrectable words.

module ecc_11to16 (
    input  logic [10:0] enc_in,
    output logic [15:0] enc_out,
    input  logic [15:0] dec_in,
    output logic [10:0] dec_out,
    output logic        err_correct,
    output logic        err_uncorrect
);

    // Extended Hamming(16,11): codeword bit i is Hamming position i, bit 0 is overall parity.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c       = '0;
        c[3]    = d[0];
        c[7:5]  = d[3:1];
        c[15:9] = d[10:4];
        c[1]    = ^(c & 16'hAAAA);
        c[2]    = ^(c & 16'hCCCC);
        c[4]    = ^(c & 16'hF0F0);
        c[8]    = ^(c & 16'hFF00);
        c[0]    = ^c;
        return c;
    endfunction

    logic [3:0]  syndrome;
    logic        parity;
    logic [15:0] fixed;

    always_comb begin
        enc_out  = encode(enc_in);
        syndrome = {^(dec_in & 16'hFF00), ^(dec_in & 16'hF0F0),
                    ^(dec_in & 16'hCCCC), ^(dec_in & 16'hAAAA)};
        parity   = ^dec_in;
        // Odd overall parity means one flipped bit; syndrome 0 then points at the parity bit itself.
        fixed         = parity ? (dec_in ^ (16'd1 << syndrome)) : dec_in;
        err_correct   = parity;
        err_uncorrect = !parity && (syndrome != 4'd0);
        dec_out       = {fixed[15:9], fixed[7:5], fixed[3]};
    end

endmodule

module ecc_scrub_ctrl #(
    parameter int ADDR_W         = 6,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [10:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [10:0]       host_rdata,
    output logic              host_rcorr,
    output logic              host_runc,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              scrub_busy,
    output logic [ADDR_W-1:0] scrub_ptr,
    output logic [15:0]       cnt_corr,
    output logic [15:0]       cnt_unc,
    output logic [ADDR_W-1:0] last_unc_addr,
    output logic              irq_unc
);

    localparam int IVL_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HOST_RD,
        SCRUB_RD,
        SCRUB_CHK,
        SCRUB_WB
    } state_t;

    state_t            state;
    logic [IVL_W-1:0]  ivl_cnt;
    logic              scrub_pend;
    logic [2:0]        streak;
    logic [15:0]       wb_code_p1;
    logic [ADDR_W-1:0] rd_addr_p1;

    logic [10:0] enc_in;
    logic [15:0] enc_out;
    logic [10:0] dec_out;
    logic        err_correct;
    logic        err_uncorrect;

    logic scrub_req;
    logic scrub_wins;
    logic scrub_start;
    logic corr_evt;
    logic unc_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ecc_11to16 u_ecc (
        .enc_in       (enc_in),
        .enc_out      (enc_out),
        .dec_in       (mem_rdata),
        .dec_out      (dec_out),
        .err_correct  (err_correct),
        .err_uncorrect(err_uncorrect)
    );

    always_comb begin
        scrub_req   = scrub_pend && scrub_en;
        // After four host grants in a row against a waiting scrub, the scrub takes the next IDLE cycle.
        scrub_wins  = scrub_req && (streak == 3'd4);
        host_gnt    = !rst && (state == IDLE) && host_req && !scrub_wins;
        scrub_start = !rst && (state == IDLE) && scrub_req && !host_gnt;
        enc_in      = (state == IDLE) ? host_wdata : dec_out;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (host_gnt) begin
                        mem_en    = 1'b1;
                        mem_we    = host_we;
                        mem_addr  = host_addr;
                        mem_wdata = host_we ? enc_out : 16'd0;
                    end
                end
                SCRUB_RD: begin
                    mem_en   = 1'b1;
                    mem_addr = scrub_ptr;
                end
                SCRUB_WB: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = scrub_ptr;
                    mem_wdata = wb_code_p1;
                end
                default: ;
            endcase
        end

        host_rvalid = !rst && (state == HOST_RD);
        host_rdata  = host_rvalid ? dec_out : 11'd0;
        host_rcorr  = host_rvalid && err_correct;
        host_runc   = host_rvalid && err_uncorrect;
        scrub_busy  = !rst && ((state == SCRUB_RD) || (state == SCRUB_CHK) || (state == SCRUB_WB));

        corr_evt = host_rcorr || (!rst && (state == SCRUB_WB));
        unc_evt  = host_runc || (!rst && (state == SCRUB_CHK) && err_uncorrect);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ivl_cnt       <= '0;
            scrub_pend    <= 1'b0;
            streak        <= '0;
            scrub_ptr     <= '0;
            cnt_corr      <= '0;
            cnt_unc       <= '0;
            last_unc_addr <= '0;
            irq_unc       <= 1'b0;
        end else begin
            irq_unc <= unc_evt;
            if (corr_evt) cnt_corr <= sat_inc(cnt_corr);
            if (unc_evt)  cnt_unc  <= sat_inc(cnt_unc);

            if (!scrub_en) begin
                ivl_cnt    <= '0;
                scrub_pend <= 1'b0;
            end else if (scrub_start) begin
                scrub_pend <= 1'b0;
            end else if (!scrub_pend) begin
                if (ivl_cnt == IVL_W'(SCRUB_INTERVAL - 1)) begin
                    ivl_cnt    <= '0;
                    scrub_pend <= 1'b1;
                end else begin
                    ivl_cnt <= ivl_cnt + IVL_W'(1);
                end
            end

            if (scrub_start || !scrub_req)
                streak <= '0;
            else if (host_gnt)
                streak <= streak + 3'd1;

            case (state)
                IDLE: begin
                    if (host_gnt && !host_we)
                        state <= HOST_RD;
                    else if (scrub_start)
                        state <= SCRUB_RD;
                end
                HOST_RD: begin
                    if (err_uncorrect) last_unc_addr <= rd_addr_p1;
                    state <= IDLE;
                end
                SCRUB_RD: state <= SCRUB_CHK;
                SCRUB_CHK: begin
                    if (err_correct) begin
                        state <= SCRUB_WB;
                    end else begin
                        if (err_uncorrect) last_unc_addr <= scrub_ptr;
                        scrub_ptr <= scrub_ptr + ADDR_W'(1);
                        state     <= IDLE;
                    end
                end
                SCRUB_WB: begin
                    scrub_ptr <= scrub_ptr + ADDR_W'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data-only registers: the corrected codeword and the address of the read in flight.
    always_ff @(posedge clk) begin
        if (state == SCRUB_CHK && err_correct) wb_code_p1 <= enc_out;
        if (host_gnt) rd_addr_p1 <= host_addr;
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural one-cycle-latency memory
// and fault injection into stored codewords.

module tb_ecc_scrub_ctrl;

    localparam int ADDR_W         = 6;
    localparam int SCRUB_INTERVAL = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              scrub_en = 1'b0;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [10:0]       host_wdata = '0;
    logic              host_gnt;
    logic              host_rvalid;
    logic [10:0]       host_rdata;
    logic              host_rcorr;
    logic              host_runc;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata = '0;
    logic              scrub_busy;
    logic [ADDR_W-1:0] scrub_ptr;
    logic [15:0]       cnt_corr;
    logic [15:0]       cnt_unc;
    logic [ADDR_W-1:0] last_unc_addr;
    logic              irq_unc;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SCRUB_INTERVAL)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_rcorr(host_rcorr), .host_runc(host_runc),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .scrub_busy(scrub_busy), .scrub_ptr(scrub_ptr),
        .cnt_corr(cnt_corr), .cnt_unc(cnt_unc), .last_unc_addr(last_unc_addr), .irq_unc(irq_unc)
    );

    logic [15:0]       mem [0:63] = '{default: 16'h0000};
    int                wr_cnt [0:63] = '{default: 0};
    logic              inj_req = 1'b0;
    logic [ADDR_W-1:0] inj_addr = '0;
    logic [15:0]       inj_mask = '0;
    int                sc_wr_cnt = 0;
    logic [ADDR_W-1:0] sc_wr_addr = '0;
    logic [15:0]       sc_wr_data = '0;
    int                irq_hi = 0;
    int                irq_pulses = 0;
    logic              irq_prev = 1'b0;

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]    <= mem_wdata;
            wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
            if (scrub_busy) begin
                sc_wr_cnt  <= sc_wr_cnt + 1;
                sc_wr_addr <= mem_addr;
                sc_wr_data <= mem_wdata;
            end
        end
        if (inj_req) mem[inj_addr] <= mem[inj_addr] ^ inj_mask;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        if (irq_unc) irq_hi <= irq_hi + 1;
        if (irq_unc && !irq_prev) irq_pulses <= irq_pulses + 1;
        irq_prev <= irq_unc;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inject(input logic [ADDR_W-1:0] a, input logic [15:0] m);
        inj_addr = a;
        inj_mask = m;
        inj_req  = 1'b1;
        @(negedge clk);
        inj_req  = 1'b0;
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [10:0] d,
                              input logic chk_code, input logic [15:0] code);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        check("wr_gnt", 32'(host_gnt), 1);
        check("wr_mem_we", 32'({mem_en, mem_we}), 3);
        check("wr_mem_addr", 32'(mem_addr), 32'(a));
        if (chk_code) check("wr_codeword", 32'(mem_wdata), 32'(code));
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic chk_data, input logic [10:0] d,
                             input logic corr, input logic unc);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        #1;
        check("rd_gnt", 32'(host_gnt), 1);
        check("rd_mem_strobe", 32'({mem_en, mem_we}), 2);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check("rd_rvalid", 32'(host_rvalid), 1);
        if (chk_data) check("rd_data", 32'(host_rdata), 32'(d));
        check("rd_corr", 32'(host_rcorr), 32'(corr));
        check("rd_unc", 32'(host_runc), 32'(unc));
        @(negedge clk);
    endtask

    task automatic wait_ptr(input logic [ADDR_W-1:0] target, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (scrub_ptr !== target && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(scrub_ptr), 32'(target));
    endtask

    logic [19:0] gvec;
    logic [19:0] bvec;

    initial begin
        // Reset state
        tick(3);
        check("rst_outputs", 32'({host_gnt, host_rvalid, mem_en, mem_we, scrub_busy, irq_unc}), 0);
        rst = 1'b0;
        tick(1);
        check("rst_ptr", 32'(scrub_ptr), 0);
        check("rst_counters", 32'({cnt_corr, cnt_unc}), 0);
        check("rst_last_unc", 32'(last_unc_addr), 0);

        // Host write then read back; 0x5A3 encodes to 0xB42D
        host_write(6'd3, 11'h5A3, 1'b1, 16'hB42D);
        host_read(6'd3, 1'b1, 11'h5A3, 1'b0, 1'b0);

        // Seed a single-bit error at addr 0 and a double-bit error at addr 5
        host_write(6'd0, 11'h5A3, 1'b0, 16'h0);
        inject(6'd0, 16'h0080);
        host_write(6'd5, 11'h123, 1'b0, 16'h0);
        inject(6'd5, 16'h0042);
        check("pre_scrub_wr5", 32'(wr_cnt[5]), 1);
        scrub_en = 1'b1;
        wait_ptr(6'd1, 100, "scrub_ptr_after_wb");
        check("scrub_cnt_corr", 32'(cnt_corr), 1);
        check("scrub_wb_count", 32'(sc_wr_cnt), 1);
        check("scrub_wb_addr", 32'(sc_wr_addr), 0);
        check("scrub_wb_data", 32'(sc_wr_data), 32'hB42D);
        check("mem0_repaired", 32'(mem[0]), 32'hB42D);
        wait_ptr(6'd6, 200, "scrub_ptr_after_unc");
        check("scrub_cnt_unc", 32'(cnt_unc), 1);
        check("scrub_last_unc", 32'(last_unc_addr), 5);
        check("scrub_no_wr5", 32'(wr_cnt[5]), 1);
        wait_ptr(6'd0, 1000, "scrub_ptr_wrap");
        scrub_en = 1'b0;
        check("wrap_cnt_corr", 32'(cnt_corr), 1);
        check("wrap_cnt_unc", 32'(cnt_unc), 1);
        check("irq_high_cycles", 32'(irq_hi), 1);
        check("irq_pulses", 32'(irq_pulses), 1);
        tick(3);

        // Host reads with corrected and uncorrectable words
        inject(6'd3, 16'h0004);
        host_read(6'd3, 1'b1, 11'h5A3, 1'b1, 1'b0);
        check("host_cnt_corr", 32'(cnt_corr), 2);
        host_write(6'd9, 11'h7FF, 1'b0, 16'h0);
        inject(6'd9, 16'h0810);
        host_read(6'd9, 1'b0, 11'h0, 1'b0, 1'b1);
        check("host_irq", 32'(irq_unc), 1);
        check("host_cnt_unc", 32'(cnt_unc), 2);
        check("host_last_unc", 32'(last_unc_addr), 9);
        @(negedge clk);
        check("host_irq_one_cycle", 32'(irq_unc), 0);

        // Corrected-error counter saturation
        force dut.cnt_corr = 16'hFFFF;
        #1;
        release dut.cnt_corr;
        @(negedge clk);
        host_read(6'd3, 1'b1, 11'h5A3, 1'b1, 1'b0);
        check("cnt_corr_sat", 32'(cnt_corr), 32'hFFFF);

        // Continuous host writes against a pending scrub
        check("arb_start_ptr", 32'(scrub_ptr), 0);
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'd10; host_wdata = 11'h000;
        scrub_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            gvec[i] = host_gnt;
            bvec[i] = scrub_busy;
            @(negedge clk);
        end
        host_req = 1'b0; host_we = 1'b0;
        scrub_en = 1'b0;
        check("arb_gnt_pattern", 32'(gvec), 32'h1F8FF);
        check("arb_busy_pattern", 32'(bvec), 32'hC0600);
        check("arb_end_ptr", 32'(scrub_ptr), 2);
        tick(2);

        // Reset during SCRUB_CHK of a correctable word
        inject(6'd2, 16'h0001);
        scrub_en = 1'b1;
        begin
            int n;
            n = 0;
            while (!scrub_busy && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("abort_reached_rd", 32'(scrub_busy), 1);
        @(negedge clk);
        check("abort_in_chk", 32'(scrub_busy), 1);
        rst = 1'b1;
        #1;
        check("abort_no_strobe", 32'({mem_en, mem_we, scrub_busy}), 0);
        @(negedge clk);
        check("abort_outputs", 32'({mem_en, mem_we, scrub_busy, irq_unc, host_rvalid}), 0);
        check("abort_ptr", 32'(scrub_ptr), 0);
        check("abort_counters", 32'({cnt_corr, cnt_unc}), 0);
        check("abort_last_unc", 32'(last_unc_addr), 0);
        check("abort_no_wr2", 32'(wr_cnt[2]), 0);
        check("abort_mem2", 32'(mem[2]), 32'h0001);
        scrub_en = 1'b0;
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
